// File: rtl/sm3_pkg.sv
// Shared definitions for the SM3 message feeder.
//   - pad_en command codes driven to the padder
//   - SM3 block / length-field / digest geometry in bytes
//   - feeder FSM state enum
//   - final_count(): FINAL-phase length for a tail of mb bytes
package sm3_pkg;

  localparam logic [1:0] PAD_CLEAR = 2'd0;
  localparam logic [1:0] PAD_DATA  = 2'd1;
  localparam logic [1:0] PAD_FINAL = 2'd2;
  localparam logic [1:0] PAD_HOLD  = 2'd3;

  localparam int unsigned SM3_BLOCK_BYTES  = 64;
  localparam int unsigned SM3_LEN_OFFSET   = 56;
  localparam int unsigned SM3_DIGEST_BYTES = 32;

  typedef enum logic [2:0] {
    StIdle,
    StFeed,
    StCommit,
    StWaitCf,
    StFinal,
    StCapture,
    StDout
  } feeder_state_e;

  // Zero-pad cycles up to the length field, plus one length cycle and one commit cycle.
  function automatic logic [5:0] final_count(input logic [5:0] mb);
    return 6'(SM3_LEN_OFFSET + 2) - mb;
  endfunction

endpackage

// File: rtl/sm3_digest_ser.sv
// 256-bit digest serializer: parallel load, then MSB-first byte stream over valid/ready.
//   clk, rst_n          clock, async active-low reset
//   load, din[255:0]    capture a new digest (starts streaming next cycle)
//   d_byte/d_valid      current digest byte
//   d_ready             sink ready; a handshake shifts out one byte
//   d_last              high while byte 31 is presented
module sm3_digest_ser
  import sm3_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [255:0] din,
  input  logic         d_ready,
  output logic [7:0]   d_byte,
  output logic         d_valid,
  output logic         d_last
);

  logic [255:0] sr_q, sr_d;
  logic [4:0]   idx_q, idx_d;
  logic         valid_q, valid_d;

  always_comb begin
    sr_d    = sr_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    if (load) begin
      sr_d    = din;
      idx_d   = '0;
      valid_d = 1'b1;
    end else if (valid_q && d_ready) begin
      sr_d  = {sr_q[247:0], 8'h00};
      idx_d = idx_q + 5'd1;
      if (d_last) begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q    <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      sr_q    <= sr_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

  assign d_byte  = sr_q[255:248];
  assign d_valid = valid_q;
  assign d_last  = valid_q && (idx_q == 5'(SM3_DIGEST_BYTES - 1));

endmodule

// File: rtl/sm3_msg_feeder.sv
// SM3 message feeder: takes a byte-stream message (valid/ready) and sequences the padder's
// command port (clear / data / commit / hold), waits out each compression, issues the final
// padding run, then captures the 256-bit digest and streams it out MSB first.
//   s_byte/s_valid/s_last/s_ready   message input
//   pad_en/pad_byte                 padder command and data byte (registered)
//   pad_digest/pad_done             padder outputV and finishedOneBlock
//   d_byte/d_valid/d_ready/d_last   digest output stream
//   busy                            not idle
//   err                             one-cycle pulse: tail too long or digest not ready
module sm3_msg_feeder
  import sm3_pkg::*;
#(
  parameter int unsigned CF_LAT = 68
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   s_byte,
  input  logic         s_valid,
  input  logic         s_last,
  output logic         s_ready,
  output logic [1:0]   pad_en,
  output logic [7:0]   pad_byte,
  input  logic [255:0] pad_digest,
  input  logic         pad_done,
  output logic [7:0]   d_byte,
  output logic         d_valid,
  input  logic         d_ready,
  output logic         d_last,
  output logic         busy,
  output logic         err
);

  localparam int unsigned       WaitW    = $clog2(CF_LAT + 1);
  localparam logic [WaitW-1:0] WaitLoad = WaitW'(CF_LAT);

  feeder_state_e    state_q, state_d;
  logic [5:0]       m_q, m_d;
  logic [5:0]       fin_q, fin_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic             last_f_q, last_f_d;
  logic             final_f_q, final_f_d;
  logic [1:0]       pad_en_q, pad_en_d;
  logic [7:0]       pad_byte_q, pad_byte_d;
  logic             err_q, err_d;
  logic             ser_load;
  logic             accept;
  logic [5:0]       mb;

  assign accept = s_valid && (state_q == StFeed);
  assign mb     = m_q + 6'd1;

  always_comb begin
    state_d    = state_q;
    m_d        = m_q;
    fin_d      = fin_q;
    wait_d     = wait_q;
    last_f_d   = last_f_q;
    final_f_d  = final_f_q;
    pad_en_d   = PAD_HOLD;
    pad_byte_d = pad_byte_q;
    err_d      = 1'b0;
    ser_load   = 1'b0;
    unique case (state_q)
      StIdle: begin
        pad_en_d  = PAD_CLEAR;
        m_d       = '0;
        last_f_d  = 1'b0;
        final_f_d = 1'b0;
        if (s_valid) begin
          state_d = StFeed;
        end
      end
      StFeed: begin
        if (accept) begin
          pad_en_d   = PAD_DATA;
          pad_byte_d = s_byte;
          m_d        = mb;
          if (m_q == 6'(SM3_BLOCK_BYTES - 1)) begin
            state_d  = StCommit;
            last_f_d = s_last;
          end else if (s_last) begin
            // The padder cannot spill the length field into a second block.
            if (mb >= 6'(SM3_LEN_OFFSET)) begin
              err_d   = 1'b1;
              state_d = StIdle;
            end else begin
              fin_d   = final_count(mb);
              state_d = StFinal;
            end
          end
        end
      end
      StCommit: begin
        pad_en_d = PAD_FINAL;
        m_d      = '0;
        wait_d   = WaitLoad;
        state_d  = StWaitCf;
      end
      StWaitCf: begin
        wait_d = wait_q - WaitW'(1);
        if (wait_q <= WaitW'(1)) begin
          if (final_f_q) begin
            state_d = StCapture;
          end else if (last_f_q) begin
            // Message ended exactly on a block boundary: empty tail block.
            fin_d   = final_count(6'd0);
            state_d = StFinal;
          end else begin
            state_d = StFeed;
          end
        end
      end
      StFinal: begin
        pad_en_d = PAD_FINAL;
        fin_d    = fin_q - 6'd1;
        if (fin_q <= 6'd1) begin
          final_f_d = 1'b1;
          wait_d    = WaitLoad;
          state_d   = StWaitCf;
        end
      end
      StCapture: begin
        if (!pad_done) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          ser_load = 1'b1;
          state_d  = StDout;
        end
      end
      StDout: begin
        if (d_valid && d_ready && d_last) begin
          state_d   = StIdle;
          m_d       = '0;
          last_f_d  = 1'b0;
          final_f_d = 1'b0;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      m_q        <= '0;
      fin_q      <= '0;
      wait_q     <= '0;
      last_f_q   <= 1'b0;
      final_f_q  <= 1'b0;
      pad_en_q   <= PAD_CLEAR;
      pad_byte_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      m_q        <= m_d;
      fin_q      <= fin_d;
      wait_q     <= wait_d;
      last_f_q   <= last_f_d;
      final_f_q  <= final_f_d;
      pad_en_q   <= pad_en_d;
      pad_byte_q <= pad_byte_d;
      err_q      <= err_d;
    end
  end

  sm3_digest_ser u_ser (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (ser_load),
    .din     (pad_digest),
    .d_ready (d_ready),
    .d_byte  (d_byte),
    .d_valid (d_valid),
    .d_last  (d_last)
  );

  assign s_ready  = (state_q == StFeed);
  assign busy     = (state_q != StIdle);
  assign pad_en   = pad_en_q;
  assign pad_byte = pad_byte_q;
  assign err      = err_q;

endmodule

// File: tb/tb_sm3_msg_feeder.sv
// Directed bench for sm3_msg_feeder. The bench plays the padder: it presents a known digest
// on pad_digest and records the pad_en / pad_byte / s_ready / err / d_valid trace each cycle.
module tb_sm3_msg_feeder;
  import sm3_pkg::*;

  localparam int unsigned CF_LAT = 68;

  localparam logic [255:0] ABC_DIG =
    256'h66c7f0f4_62eeedd9_d1f2d46b_dc10e4e2_4167c487_5cf2f7a2_297da02b_8f4ba8e0;
  localparam logic [255:0] DIG2 =
    256'h00010203_04050607_08090a0b_0c0d0e0f_10111213_14151617_18191a1b_1c1d1e1f;
  localparam logic [255:0] DIG3 =
    256'hf0e1d2c3_b4a59687_78695a4b_3c2d1e0f_0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [7:0]   s_byte = '0;
  logic         s_valid = 1'b0;
  logic         s_last = 1'b0;
  logic         s_ready;
  logic [1:0]   pad_en;
  logic [7:0]   pad_byte;
  logic [255:0] pad_digest = '0;
  logic         pad_done = 1'b1;
  logic [7:0]   d_byte;
  logic         d_valid;
  logic         d_ready = 1'b1;
  logic         d_last;
  logic         busy;
  logic         err;

  int n_checks = 0;
  int n_fail = 0;

  sm3_msg_feeder #(.CF_LAT(CF_LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_byte     (s_byte),
    .s_valid    (s_valid),
    .s_last     (s_last),
    .s_ready    (s_ready),
    .pad_en     (pad_en),
    .pad_byte   (pad_byte),
    .pad_digest (pad_digest),
    .pad_done   (pad_done),
    .d_byte     (d_byte),
    .d_valid    (d_valid),
    .d_ready    (d_ready),
    .d_last     (d_last),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Per-cycle trace, sampled mid-cycle.
  bit         trace_on = 1'b0;
  logic [1:0] tr_pad[$];
  logic [7:0] tr_byte[$];
  bit         tr_rdy[$];
  bit         tr_err[$];
  bit         tr_dv[$];

  always @(negedge clk) begin
    if (trace_on) begin
      tr_pad.push_back(pad_en);
      tr_byte.push_back(pad_byte);
      tr_rdy.push_back(s_ready);
      tr_err.push_back(err);
      tr_dv.push_back(d_valid);
    end
  end

  task automatic trace_start();
    tr_pad.delete();
    tr_byte.delete();
    tr_rdy.delete();
    tr_err.delete();
    tr_dv.delete();
    trace_on = 1'b1;
  endtask

  // Run-length encoding of the pad_en trace.
  int run_val[$];
  int run_len[$];
  int run_start[$];

  function automatic void build_runs();
    run_val.delete();
    run_len.delete();
    run_start.delete();
    for (int i = 0; i < tr_pad.size(); i++) begin
      if (i == 0 || tr_pad[i] != tr_pad[i-1]) begin
        run_val.push_back(int'(tr_pad[i]));
        run_len.push_back(1);
        run_start.push_back(i);
      end else begin
        run_len[run_len.size()-1]++;
      end
    end
  endfunction

  function automatic string runs_str();
    string s = "";
    for (int i = 0; i < run_val.size() && i < 10; i++) begin
      s = {s, $sformatf("%0dx%0d ", run_val[i], run_len[i])};
    end
    return s;
  endfunction

  logic [7:0] msg[$];

  task automatic set_msg_abc();
    msg.delete();
    msg.push_back(8'h61);
    msg.push_back(8'h62);
    msg.push_back(8'h63);
  endtask

  // Sends msg[]; gaps inserts one idle cycle after every accepted byte.
  task automatic send_msg(input bit gaps, output bit timeout);
    int budget = 0;
    timeout = 1'b0;
    for (int i = 0; i < msg.size(); i++) begin
      s_valid = 1'b1;
      s_byte  = msg[i];
      s_last  = (i == msg.size() - 1);
      forever begin
        @(negedge clk);
        budget++;
        if (s_ready || budget > 5000) break;
        @(posedge clk);
        #1;
      end
      @(posedge clk);
      #1;
      if (budget > 5000) begin
        timeout = 1'b1;
        break;
      end
      if (gaps) begin
        s_valid = 1'b0;
        s_last  = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_byte  = '0;
  endtask

  // Collects digest bytes; after stall_at bytes, holds d_ready low for 10 cycles and notes
  // whether d_valid/d_byte stayed put.
  task automatic recv_digest(input int stall_at, output logic [255:0] dig, output int nbytes,
                             output int last_pos, output bit stall_ok, output bit timeout);
    int         cyc = 0;
    logic [7:0] held;
    dig      = '0;
    nbytes   = 0;
    last_pos = -1;
    stall_ok = 1'b1;
    timeout  = 1'b0;
    d_ready  = 1'b1;
    while (nbytes < 32) begin
      @(negedge clk);
      if (d_valid) begin
        dig = {dig[247:0], d_byte};
        if (d_last) last_pos = nbytes;
        nbytes++;
        if (d_last) break;
        if (nbytes == stall_at) begin
          @(posedge clk);
          #1;
          d_ready = 1'b0;
          @(negedge clk);
          held = d_byte;
          for (int k = 0; k < 10; k++) begin
            if (k > 0) @(negedge clk);
            if (!d_valid || d_byte !== held) stall_ok = 1'b0;
          end
          @(posedge clk);
          #1;
          d_ready = 1'b1;
          continue;
        end
      end
      cyc++;
      if (cyc > 2000) begin
        timeout = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    s_valid = 1'b1;
    s_byte  = 8'hAA;
    s_last  = 1'b1;
    rst_n   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({pad_en, pad_byte, s_ready, d_valid, d_last, d_byte, busy, err} !== 23'd0) begin
      n_fail++;
      $display("FAIL reset_values: pad_en=%0d pad_byte=%h s_ready=%b d_valid=%b d_last=%b d_byte=%h busy=%b err=%b, required all zero",
               pad_en, pad_byte, s_ready, d_valid, d_last, d_byte, busy, err);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_byte  = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0 || s_ready !== 1'b0 || pad_en !== PAD_CLEAR) begin
      n_fail++;
      $display("FAIL idle_after_reset: busy=%b s_ready=%b pad_en=%0d, required 0 0 0",
               busy, s_ready, pad_en);
    end
  endtask

  task automatic test_abc();
    bit           to, to2, st;
    logic [255:0] dig;
    int           nb, lp, ones, errs;
    logic [23:0]  got;
    set_msg_abc();
    pad_digest = ABC_DIG;
    trace_start();
    send_msg(1'b0, to);
    recv_digest(0, dig, nb, lp, st, to2);
    repeat (3) @(posedge clk);
    #1;
    trace_on = 1'b0;
    n_checks++;
    if (to || to2) begin
      n_fail++;
      $display("FAIL abc_timeout: send=%b recv=%b, required 0 0", to, to2);
    end
    build_runs();
    // 3s cover CF_LAT wait cycles, the capture cycle and 32 digest cycles.
    n_checks++;
    if (run_val.size() < 5 || run_val[0] != 0 || run_val[1] != 1 || run_len[1] != 3 ||
        run_val[2] != 2 || run_len[2] != 55 || run_val[3] != 3 ||
        run_len[3] != CF_LAT + 33 || run_val[4] != 0) begin
      n_fail++;
      $display("FAIL abc_pad_trace: got %s, required 0xN 1x3 2x55 3x%0d 0xN",
               runs_str(), CF_LAT + 33);
    end
    ones = 0;
    got  = '0;
    errs = 0;
    for (int i = 0; i < tr_pad.size(); i++) begin
      if (tr_pad[i] == PAD_DATA) begin
        ones++;
        got = {got[15:0], tr_byte[i]};
      end
      if (tr_err[i]) errs++;
    end
    n_checks++;
    if (ones != 3 || got !== 24'h616263) begin
      n_fail++;
      $display("FAIL abc_pad_bytes: count=%0d bytes=%h, required 3 616263", ones, got);
    end
    n_checks++;
    if (dig !== ABC_DIG || nb != 32 || lp != 31) begin
      n_fail++;
      $display("FAIL abc_digest: got %h n=%0d last=%0d, required %h n=32 last=31",
               dig, nb, lp, ABC_DIG);
    end
    n_checks++;
    if (errs != 0) begin
      n_fail++;
      $display("FAIL abc_no_err: err cycles=%0d, required 0", errs);
    end
  endtask

  task automatic test_full_block();
    bit           to, to2, st;
    logic [255:0] dig;
    int           nb, lp;
    msg.delete();
    for (int i = 0; i < 64; i++) msg.push_back(8'h61);
    pad_digest = DIG2;
    trace_start();
    send_msg(1'b0, to);
    recv_digest(0, dig, nb, lp, st, to2);
    repeat (3) @(posedge clk);
    #1;
    trace_on = 1'b0;
    build_runs();
    n_checks++;
    if (to || to2 || run_val.size() < 7 || run_val[1] != 1 || run_len[1] != 64 ||
        run_val[2] != 2 || run_len[2] != 1 || run_val[3] != 3 || run_len[3] != CF_LAT ||
        run_val[4] != 2 || run_len[4] != 58 || run_val[5] != 3 ||
        run_len[5] != CF_LAT + 33 || run_val[6] != 0) begin
      n_fail++;
      $display("FAIL full_block_pad_trace: got %s to=%b/%b, required 0xN 1x64 2x1 3x%0d 2x58 3x%0d 0xN",
               runs_str(), to, to2, CF_LAT, CF_LAT + 33);
    end
    n_checks++;
    if (dig !== DIG2 || nb != 32 || lp != 31) begin
      n_fail++;
      $display("FAIL full_block_digest: got %h n=%0d last=%0d, required %h n=32 last=31",
               dig, nb, lp, DIG2);
    end
  endtask

  task automatic test_len56_err();
    bit to;
    int ones, idx56, errs, erri, dvs;
    msg.delete();
    for (int i = 0; i < 56; i++) msg.push_back(8'(i + 1));
    pad_digest = DIG2;
    trace_start();
    send_msg(1'b0, to);
    repeat (150) @(posedge clk);
    #1;
    trace_on = 1'b0;
    ones  = 0;
    idx56 = -1;
    errs  = 0;
    erri  = -1;
    dvs   = 0;
    for (int i = 0; i < tr_pad.size(); i++) begin
      if (tr_pad[i] == PAD_DATA) begin
        ones++;
        if (ones == 56) idx56 = i;
      end
      if (tr_err[i]) begin
        errs++;
        if (erri < 0) erri = i;
      end
      if (tr_dv[i]) dvs++;
    end
    n_checks++;
    if (to || errs != 1) begin
      n_fail++;
      $display("FAIL len56_err_count: err cycles=%0d to=%b, required 1 0", errs, to);
    end
    n_checks++;
    if (idx56 < 0 || erri != idx56) begin
      n_fail++;
      $display("FAIL len56_err_timing: err at %0d, byte 56 on padder at %0d, required equal",
               erri, idx56);
    end
    n_checks++;
    if (erri < 0 || erri + 1 >= tr_pad.size() || tr_pad[erri+1] != PAD_CLEAR) begin
      n_fail++;
      $display("FAIL len56_back_to_idle: pad_en after err not CLEAR (err idx %0d), required 0",
               erri);
    end
    n_checks++;
    if (dvs != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL len56_no_digest: d_valid cycles=%0d busy=%b, required 0 0", dvs, busy);
    end
  endtask

  task automatic test_back_to_back();
    bit           to, to2, st;
    logic [255:0] dig;
    int           nb, lp, ones, bytes_bad, gaps_bad, commits, last2, rdy_bad, p;
    msg.delete();
    for (int i = 0; i < 130; i++) msg.push_back(8'(i));
    pad_digest = DIG3;
    trace_start();
    send_msg(1'b1, to);
    recv_digest(0, dig, nb, lp, st, to2);
    repeat (3) @(posedge clk);
    #1;
    trace_on = 1'b0;
    ones      = 0;
    bytes_bad = 0;
    gaps_bad  = 0;
    for (int i = 0; i < tr_pad.size(); i++) begin
      if (tr_pad[i] == PAD_DATA) begin
        if (tr_byte[i] !== 8'(ones)) bytes_bad++;
        ones++;
        if (i + 2 < tr_pad.size() && tr_pad[i+2] == PAD_DATA && tr_pad[i+1] != PAD_HOLD)
          gaps_bad++;
        if (i + 1 < tr_pad.size() && tr_pad[i+1] == PAD_DATA) gaps_bad++;
      end
    end
    n_checks++;
    if (to || ones != 130 || bytes_bad != 0) begin
      n_fail++;
      $display("FAIL b2b_data: bytes=%0d wrong=%0d to=%b, required 130 0 0",
               ones, bytes_bad, to);
    end
    n_checks++;
    if (gaps_bad != 0) begin
      n_fail++;
      $display("FAIL b2b_gap_hold: bad gaps=%0d, required 0", gaps_bad);
    end
    build_runs();
    commits = 0;
    last2   = -1;
    rdy_bad = 0;
    for (int r = 0; r < run_val.size(); r++) begin
      if (run_val[r] == 2) begin
        last2 = r;
        if (run_len[r] == 1) begin
          commits++;
          // Commit state sits one cycle ahead of its registered pad_en.
          p = run_start[r];
          for (int j = p - 1; j < p + int'(CF_LAT) && j < tr_rdy.size(); j++) begin
            if (j >= 0 && tr_rdy[j]) rdy_bad++;
          end
        end
      end
    end
    n_checks++;
    if (commits != 2 || last2 < 0 || run_len[last2] != 56) begin
      n_fail++;
      $display("FAIL b2b_commits: commits=%0d runs %s, required 2 commits and final 2x56",
               commits, runs_str());
    end
    n_checks++;
    if (rdy_bad != 0) begin
      n_fail++;
      $display("FAIL b2b_ready_low: s_ready high in commit/wait cycles=%0d, required 0",
               rdy_bad);
    end
    n_checks++;
    if (to2 || dig !== DIG3 || nb != 32 || lp != 31) begin
      n_fail++;
      $display("FAIL b2b_digest: got %h n=%0d last=%0d, required %h n=32 last=31",
               dig, nb, lp, DIG3);
    end
  endtask

  task automatic test_dstall();
    bit           to, to2, st;
    logic [255:0] dig;
    int           nb, lp;
    set_msg_abc();
    pad_digest = ABC_DIG;
    send_msg(1'b0, to);
    recv_digest(10, dig, nb, lp, st, to2);
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (!st) begin
      n_fail++;
      $display("FAIL dstall_hold: d_valid/d_byte moved while d_ready low, required stable");
    end
    n_checks++;
    if (to || to2 || dig !== ABC_DIG || nb != 32 || lp != 31) begin
      n_fail++;
      $display("FAIL dstall_digest: got %h n=%0d last=%0d, required %h n=32 last=31",
               dig, nb, lp, ABC_DIG);
    end
  endtask

  task automatic test_no_done();
    bit to, err_seen, dv_seen;
    set_msg_abc();
    pad_digest = DIG2;
    pad_done   = 1'b0;
    send_msg(1'b0, to);
    err_seen = 1'b0;
    dv_seen  = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (err) err_seen = 1'b1;
      if (d_valid) dv_seen = 1'b1;
    end
    n_checks++;
    if (to || !err_seen || dv_seen || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL no_done_err: err=%b d_valid=%b busy=%b, required 1 0 0",
               err_seen, dv_seen, busy);
    end
    pad_done = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_rst_final();
    bit           to, to2, st, in_final;
    logic [255:0] dig;
    int           nb, lp;
    set_msg_abc();
    pad_digest = ABC_DIG;
    send_msg(1'b0, to);
    in_final = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (pad_en == PAD_FINAL) begin
        in_final = 1'b1;
        break;
      end
    end
    n_checks++;
    if (to || !in_final) begin
      n_fail++;
      $display("FAIL rst_reach_final: reached=%b to=%b, required 1 0", in_final, to);
    end
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({pad_en, pad_byte, s_ready, d_valid, d_last, d_byte, busy, err} !== 23'd0) begin
      n_fail++;
      $display("FAIL rst_async_values: pad_en=%0d pad_byte=%h s_ready=%b d_valid=%b busy=%b err=%b, required all zero",
               pad_en, pad_byte, s_ready, d_valid, busy, err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    send_msg(1'b0, to);
    recv_digest(0, dig, nb, lp, st, to2);
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (to || to2 || dig !== ABC_DIG || nb != 32 || lp != 31) begin
      n_fail++;
      $display("FAIL rst_then_abc: got %h n=%0d last=%0d, required %h n=32 last=31",
               dig, nb, lp, ABC_DIG);
    end
  endtask

  initial begin
    test_reset();
    test_abc();
    test_full_block();
    test_len56_err();
    test_back_to_back();
    test_dstall();
    test_no_done();
    test_rst_final();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, required completion before 2ms");
    $fatal(1, "watchdog expired");
  end

endmodule
